note_sequencer: RTL

Parametrised successor to the memory-game playback/response path. It stores a level of up to MAX_LEN one-hot notes, plays them on note_outputs with programmable on/gap timing, then checks player key presses against the stored sequence. A press is registered on the edge, and the next press requires a release. It flags a mistake on a wrong note, a multi-key press or a response timeout. It sits between the game controller and the board keys/LEDs.

---
 rtl/note_sequencer_if.sv | 41 ++++
 rtl/note_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
// note_sequencer_if
//   Controller-side bundle for note_sequencer.
//   master : game controller (drives load/start, observes status)
//   slave  : note_sequencer   (consumes load/start, drives status)
//   Signals:
//     load_level     pulse, latch level_data/level_length
//     level_data     MAX_LEN packed notes, note 0 in the low N_KEYS bits
//     level_length   notes in level (clamped to MAX_LEN by the sequencer)
//     start_playback pulse, play the stored level on the LEDs
//     start_response pulse, check player key presses against the level
//     done_playback  sticky, playback finished
//     done_response  sticky, every note matched
//     made_mistake   sticky, wrong note / multi-key / timeout
//     busy           playback or response in progress
//     note_index     current 0-based note position
interface note_sequencer_if #(
  parameter int N_KEYS  = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  logic                        load_level;
  logic [MAX_LEN*N_KEYS-1:0]   level_data;
  logic [LEN_W-1:0]            level_length;
  logic                        start_playback;
  logic                        start_response;
  logic                        done_playback;
  logic                        done_response;
  logic                        made_mistake;
  logic                        busy;
  logic [LEN_W-1:0]            note_index;

  modport master (
    output load_level, level_data, level_length, start_playback, start_response,
    input  done_playback, done_response, made_mistake, busy, note_index
  );

  modport slave (
    input  load_level, level_data, level_length, start_playback, start_response,
    output done_playback, done_response, made_mistake, busy, note_index
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer
//   Stores a level of one-hot notes, plays it back on the LEDs with
//   programmable on/gap timing, then checks the player's key presses
//   against it (edge-triggered presses, release required between notes,
//   optional response timeout).
//   Ports:
//     clk          system clock
//     reset        asynchronous active-low reset
//     ctrl         controller bundle (note_sequencer_if.slave)
//     note_inputs  raw key levels, active-high, asynchronous to clk
//     note_outputs LED drive
module note_sequencer #(
  parameter int N_KEYS       = 4,
  parameter int MAX_LEN      = 16,
  parameter int LEN_W        = 5,
  parameter int NOTE_CYCLES  = 25000000,
  parameter int GAP_CYCLES   = 5000000,
  parameter int RESP_TIMEOUT = 250000000
) (
  input  logic              clk,
  input  logic              reset,
  note_sequencer_if.slave   ctrl,
  input  logic [N_KEYS-1:0] note_inputs,
  output logic [N_KEYS-1:0] note_outputs
);

  // One shared phase counter serves both the lit and dark phases.
  localparam int PH_MAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TO_W   = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [PH_W-1:0] NOTE_LAST = PH_W'(NOTE_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);
  localparam bit              TO_EN     = (RESP_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY_ON, S_PLAY_GAP, S_RESP_WAIT, S_RESP_RELEASE, S_DONE, S_MISTAKE
  } state_t;

  state_t                    state_q, state_d;
  logic [MAX_LEN*N_KEYS-1:0] level_q, level_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          idx_q, idx_d;
  logic [PH_W-1:0]           ph_q, ph_d;
  logic [TO_W-1:0]           to_q, to_d;
  logic                      done_play_q, done_play_d;
  logic                      done_resp_q, done_resp_d;
  logic                      mistake_q, mistake_d;
  logic [N_KEYS-1:0]         sync1_q, sync_keys_q, prev_keys_q;

  logic [N_KEYS-1:0] notes [MAX_LEN];
  logic [N_KEYS-1:0] cur_note;
  logic              press;
  logic              can_start;
  logic              last_note;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_notes
      assign notes[gi] = level_q[gi*N_KEYS +: N_KEYS];
    end
  endgenerate

  always_comb begin
    cur_note = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (idx_q == LEN_W'(k)) cur_note = notes[k];
    end
  end

  // A press is the first nonzero sample after an all-released sample, so a
  // key already held when the response phase begins never counts.
  assign press     = (prev_keys_q == '0) && (sync_keys_q != '0);
  assign can_start = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_MISTAKE);
  assign last_note = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    len_d       = len_q;
    idx_d       = idx_q;
    ph_d        = ph_q;
    to_d        = to_q;
    done_play_d = done_play_q;
    done_resp_d = done_resp_q;
    mistake_d   = mistake_q;

    case (state_q)
      S_IDLE, S_DONE, S_MISTAKE: begin
        // A load in the same cycle as a start takes priority so the start
        // can never run against a half-replaced level.
        if (ctrl.load_level) begin
          level_d     = ctrl.level_data;
          len_d       = (ctrl.level_length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                              : ctrl.level_length;
          done_play_d = 1'b0;
          done_resp_d = 1'b0;
          mistake_d   = 1'b0;
          idx_d       = '0;
          state_d     = S_IDLE;
        end else if (ctrl.start_playback) begin
          done_play_d = (len_q == '0);
          done_resp_d = 1'b0;
          mistake_d   = 1'b0;
          idx_d       = '0;
          ph_d        = '0;
          state_d     = (len_q == '0) ? S_DONE : S_PLAY_ON;
        end else if (ctrl.start_response) begin
          done_play_d = 1'b0;
          done_resp_d = (len_q == '0);
          mistake_d   = 1'b0;
          idx_d       = '0;
          to_d        = '0;
          state_d     = (len_q == '0) ? S_DONE : S_RESP_WAIT;
        end
      end
      S_PLAY_ON: begin
        if (ph_q == NOTE_LAST) begin
          ph_d    = '0;
          state_d = S_PLAY_GAP;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_PLAY_GAP: begin
        if (ph_q == GAP_LAST) begin
          ph_d = '0;
          if (last_note) begin
            done_play_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_PLAY_ON;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_RESP_WAIT: begin
        if (press) begin
          if (!$onehot(sync_keys_q) || (sync_keys_q != cur_note)) begin
            mistake_d = 1'b1;
            state_d   = S_MISTAKE;
          end else begin
            to_d    = '0;
            state_d = S_RESP_RELEASE;
          end
        end else if (TO_EN) begin
          if (to_q == TO_LAST) begin
            mistake_d = 1'b1;
            state_d   = S_MISTAKE;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      S_RESP_RELEASE: begin
        if (sync_keys_q == '0) begin
          if (last_note) begin
            done_resp_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_RESP_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      ph_q        <= '0;
      to_q        <= '0;
      done_play_q <= 1'b0;
      done_resp_q <= 1'b0;
      mistake_q   <= 1'b0;
      sync1_q     <= '0;
      sync_keys_q <= '0;
      prev_keys_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      ph_q        <= ph_d;
      to_q        <= to_d;
      done_play_q <= done_play_d;
      done_resp_q <= done_resp_d;
      mistake_q   <= mistake_d;
      sync1_q     <= note_inputs;
      sync_keys_q <= sync1_q;
      prev_keys_q <= sync_keys_q;
    end
  end

  always_comb begin
    note_outputs = '0;
    case (state_q)
      S_PLAY_ON:                   note_outputs = cur_note;
      S_RESP_WAIT, S_RESP_RELEASE: note_outputs = sync_keys_q;
      default:                     note_outputs = '0;
    endcase
  end

  assign ctrl.busy          = (state_q == S_PLAY_ON) || (state_q == S_PLAY_GAP) ||
                              (state_q == S_RESP_WAIT) || (state_q == S_RESP_RELEASE);
  assign ctrl.done_playback = done_play_q;
  assign ctrl.done_response = done_resp_q;
  assign ctrl.made_mistake  = mistake_q;
  assign ctrl.note_index    = idx_q;

endmodule
